// File: rtl/disp_serial_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : disp_serial_pkg                                                 |
// | Brief    : Shared types and sizing helpers for the display-link receiver.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package disp_serial_pkg;

    localparam int DATA_W_DEF         = 16;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int TIMER_W_DEF = clog2(TIMEOUT_CYCLES_DEF);

endpackage
`default_nettype wire

// File: rtl/disp_serial_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : disp_serial_rx_if                                              |
// | Brief     : Link pins and received-word outputs of the display receiver.   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface disp_serial_rx_if
    import disp_serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              sclk_in;
    logic              sdata_in;
    logic              latch_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              frame_err;

    modport master (
        output sclk_in, sdata_in, latch_in,
        input  data_out, data_valid, busy, frame_err
    );

    modport slave (
        input  sclk_in, sdata_in, latch_in,
        output data_out, data_valid, busy, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/disp_serial_rx_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_edge                                                       |
// | Brief    : Multi-flop synchronizer with rising-edge detect on the output.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_level,
    output logic      o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/disp_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_serial_rx                                                  |
// | Brief    : 3-wire display link receiver (sclk/sdata/latch), MSB first.     |
// |            Define FRAME_CHECK_EN to reject frames that are not DATA_W bits.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module disp_serial_rx
    import disp_serial_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset_in,
    disp_serial_rx_if.slave bus
);
    localparam int CNT_W   = clog2(DATA_W + 2);
    localparam int TIMER_W = clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   C_CNT_FULL   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]   C_CNT_MAX    = CNT_W'(DATA_W + 1);
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic w_sclk_rise;
    logic w_sclk_lvl_unused;
    logic w_sdata_lvl;
    logic w_sdata_rise_unused;
    logic w_latch_rise;
    logic w_latch_lvl_unused;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_next;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_cnt_shift;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_next;
    logic                w_timeout;
    logic                w_accept;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .rst     (reset_in),
        .i_d     (bus.sclk_in),
        .o_level (w_sclk_lvl_unused),
        .o_rise  (w_sclk_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk     (clk),
        .rst     (reset_in),
        .i_d     (bus.sdata_in),
        .o_level (w_sdata_lvl),
        .o_rise  (w_sdata_rise_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk     (clk),
        .rst     (reset_in),
        .i_d     (bus.latch_in),
        .o_level (w_latch_lvl_unused),
        .o_rise  (w_latch_rise)
    );

    // The shift is resolved first so a latch in the same cycle sees the new bit.
    always_comb begin
        w_shreg_next = r_shreg;
        w_cnt_shift  = r_bit_cnt;
        if (w_sclk_rise) begin
            w_shreg_next = {r_shreg[DATA_W-2:0], w_sdata_lvl};
            if (r_bit_cnt != C_CNT_MAX) begin
                w_cnt_shift = r_bit_cnt + 1'b1;
            end
        end

        w_timeout = (r_state != IDLE) && !w_sclk_rise && (r_timer == C_TIMER_LAST);

`ifdef FRAME_CHECK_EN
        w_accept = (w_cnt_shift == C_CNT_FULL);
`else
        w_accept = 1'b1;
`endif

        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_sclk_rise) w_state_next = SHIFT;
            SHIFT:   if (w_sclk_rise && (w_cnt_shift == C_CNT_FULL)) w_state_next = FULL;
            FULL:    if (w_sclk_rise) w_state_next = OVER;
            default: w_state_next = OVER;
        endcase

        w_cnt_next = w_cnt_shift;
        if (w_latch_rise || w_timeout) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end

        if ((w_state_next == IDLE) || w_sclk_rise) begin
            w_timer_next = '0;
        end else begin
            w_timer_next = r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_shreg   <= w_shreg_next;
            r_bit_cnt <= w_cnt_next;
            r_timer   <= w_timer_next;
            r_valid   <= w_latch_rise && w_accept;
            if (w_latch_rise && w_accept) begin
                r_data <= w_shreg_next;
            end
        end
    end

`ifdef FRAME_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_latch_rise && !w_accept;
        end
    end

    assign bus.frame_err = r_frame_err;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.busy       = (r_bit_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_disp_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_disp_serial_rx                                               |
// | Brief    : Self-checking bench for disp_serial_rx against a frame model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_disp_serial_rx;
    localparam int DW = 16;
    localparam int SS = 2;
    localparam int TO = 4096;
`ifdef FRAME_CHECK_EN
    localparam bit CHECKED = 1'b1;
`else
    localparam bit CHECKED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    disp_serial_rx_if #(.DATA_W(DW)) bus();

    disp_serial_rx #(
        .DATA_W         (DW),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: last DW bits ever shifted, bits in the current frame, last accepted word.
    logic [DW-1:0] m_hist;
    logic [DW-1:0] m_data;
    int            m_n;

    int            obs_v_at, obs_e_at, exp_v_at, exp_e_at;
    logic [DW-1:0] obs_data;

    task automatic model_clear();
        m_hist = '0;
        m_data = '0;
        m_n    = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.sdata_in = b;
        repeat (2) @(negedge clk);
        bus.sclk_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.sclk_in = 1'b0;
        repeat (2) @(negedge clk);
        m_hist = {m_hist[DW-2:0], b};
        m_n++;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Raises latch (and optionally sclk in the same cycle) and records pulse positions.
    task automatic pulse_latch(input bit also_sclk);
        int  vc, ec;
        bit  acc;
        acc      = CHECKED ? (m_n == DW) : 1'b1;
        vc       = 0;
        ec       = 0;
        obs_v_at = -1;
        obs_e_at = -1;
        bus.latch_in = 1'b1;
        if (also_sclk) bus.sclk_in = 1'b1;
        for (int i = 1; i <= SS + 4; i++) begin
            @(negedge clk);
            if (bus.data_valid) begin
                vc++;
                obs_v_at = (vc == 1) ? i : -2;
            end
            if (bus.frame_err) begin
                ec++;
                obs_e_at = (ec == 1) ? i : -2;
            end
        end
        bus.latch_in = 1'b0;
        bus.sclk_in  = 1'b0;
        repeat (2) @(negedge clk);
        obs_data = bus.data_out;
        exp_v_at = acc ? SS + 1 : -1;
        exp_e_at = acc ? -1 : SS + 1;
        if (acc) m_data = m_hist;
        m_n = 0;
    endtask

    task automatic test_reset();
        reset_in     = 1'b1;
        bus.sclk_in  = 1'b0;
        bus.sdata_in = 1'b0;
        bus.latch_in = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        total++; if (bus.data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.data_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
    endtask

    task automatic test_basic();
        send_word(32'hA5C3, DW);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        pulse_latch(1'b0);
        total++; if (obs_v_at !== SS + 1) begin bad++; $display("FAIL basic_valid_pos: got %0d want %0d", obs_v_at, SS + 1); end
        total++; if (obs_e_at !== -1) begin bad++; $display("FAIL basic_err_pos: got %0d want -1", obs_e_at); end
        total++; if (obs_data !== 16'hA5C3) begin bad++; $display("FAIL basic_data: got %h want a5c3", obs_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_frame();
        send_word(32'h5A, 7);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
        reset_in = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        total++; if (bus.data_out !== '0) begin bad++; $display("FAIL midrst_data: got %h want 0", bus.data_out); end
        @(negedge clk);
        @(negedge clk);
        reset_in = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_bad_length();
        send_word(32'hA5C3, DW);
        pulse_latch(1'b0);
        total++; if (obs_data !== 16'hA5C3) begin bad++; $display("FAIL len_fresh_data: got %h want a5c3", obs_data); end
        send_word($urandom, DW - 1);
        pulse_latch(1'b0);
        total++; if (obs_v_at !== exp_v_at) begin bad++; $display("FAIL short_valid_pos: got %0d want %0d", obs_v_at, exp_v_at); end
        total++; if (obs_e_at !== exp_e_at) begin bad++; $display("FAIL short_err_pos: got %0d want %0d", obs_e_at, exp_e_at); end
        total++; if (obs_data !== m_data) begin bad++; $display("FAIL short_data: got %h want %h", obs_data, m_data); end
        send_word(32'h1A5C3, DW + 1);
        pulse_latch(1'b0);
        total++; if (obs_v_at !== exp_v_at) begin bad++; $display("FAIL over_valid_pos: got %0d want %0d", obs_v_at, exp_v_at); end
        total++; if (obs_e_at !== exp_e_at) begin bad++; $display("FAIL over_err_pos: got %0d want %0d", obs_e_at, exp_e_at); end
        total++; if (obs_data !== 16'hA5C3) begin bad++; $display("FAIL over_data: got %h want a5c3", obs_data); end
    endtask

    task automatic test_simultaneous();
        send_word(32'h0000, DW - 1);
        bus.sdata_in = 1'b1;
        repeat (2) @(negedge clk);
        m_hist = {m_hist[DW-2:0], 1'b1};
        m_n++;
        pulse_latch(1'b1);
        total++; if (obs_v_at !== SS + 1) begin bad++; $display("FAIL simul_valid_pos: got %0d want %0d", obs_v_at, SS + 1); end
        total++; if (obs_e_at !== -1) begin bad++; $display("FAIL simul_err_pos: got %0d want -1", obs_e_at); end
        total++; if (obs_data !== 16'h0001) begin bad++; $display("FAIL simul_data: got %h want 0001", obs_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL simul_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int  waited;
        int  pulses;
        bit  fell;
        send_word(32'hAB, 8);
        repeat (TO / 2) @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL tmo_busy_mid: got %b want 1", bus.busy); end
        waited = 0;
        pulses = 0;
        fell   = 1'b0;
        while (!fell && waited < TO) begin
            @(negedge clk);
            waited++;
            if (bus.data_valid || bus.frame_err) pulses++;
            if (!bus.busy) fell = 1'b1;
        end
        m_n = 0;
        total++; if (fell !== 1'b1) begin bad++; $display("FAIL tmo_busy_fall: got busy=%b after %0d cycles want 0", bus.busy, waited); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL tmo_pulses: got %0d want 0", pulses); end
        send_word(32'h1234, DW);
        pulse_latch(1'b0);
        total++; if (obs_v_at !== SS + 1) begin bad++; $display("FAIL tmo_next_valid_pos: got %0d want %0d", obs_v_at, SS + 1); end
        total++; if (obs_data !== 16'h1234) begin bad++; $display("FAIL tmo_next_data: got %h want 1234", obs_data); end
    endtask

    task automatic test_empty_latch();
        pulse_latch(1'b0);
        total++; if (obs_v_at !== exp_v_at) begin bad++; $display("FAIL empty_valid_pos: got %0d want %0d", obs_v_at, exp_v_at); end
        total++; if (obs_e_at !== exp_e_at) begin bad++; $display("FAIL empty_err_pos: got %0d want %0d", obs_e_at, exp_e_at); end
        total++; if (obs_data !== m_data) begin bad++; $display("FAIL empty_data: got %h want %h", obs_data, m_data); end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 3))
                0:       len = DW;
                1:       len = DW - 1;
                2:       len = DW + 1;
                default: len = $urandom_range(0, DW + 3);
            endcase
            send_word($urandom, len);
            total++; if (bus.busy !== (m_n != 0)) begin bad++; $display("FAIL rnd%0d_busy: got %b want %b", f, bus.busy, (m_n != 0)); end
            pulse_latch(1'b0);
            total++; if (obs_v_at !== exp_v_at) begin bad++; $display("FAIL rnd%0d_valid_pos: got %0d want %0d", f, obs_v_at, exp_v_at); end
            total++; if (obs_e_at !== exp_e_at) begin bad++; $display("FAIL rnd%0d_err_pos: got %0d want %0d", f, obs_e_at, exp_e_at); end
            total++; if (obs_data !== m_data) begin bad++; $display("FAIL rnd%0d_data: got %h want %h", f, obs_data, m_data); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_reset_mid_frame();
        test_bad_length();
        test_simultaneous();
        test_timeout();
        test_empty_latch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
